rsa_avalon_bridge: RTL and testbench
====================================

# rsa_avalon_bridge

Upstream feeder and result drain for the RSA-256 decryption core. It acts as an Avalon-MM master polling an RS232 UART controller. It assembles the modulus N, private key d and each 256-bit ciphertext from serial bytes, starts the core, and streams the plaintext back out byte by byte. After N and d are loaded once, it loops over ciphertext blocks until reset.

## Interface
- RX_OFFSET, 0: Avalon address of the UART RX data register.
- TX_OFFSET, 4: Avalon address of the UART TX data register.
- STATUS_OFFSET, 8: Avalon address of the UART status register.
- RX_OK_BIT, 7: status bit meaning a received byte is available.
- TX_OK_BIT, 6: status bit meaning the TX holding register is free.
- i_clk  in  1  clock.
- i_rst  in  1  reset; asynchronous, active-low.
- avm_address  out  5  Avalon address.
- avm_read  out  1  Avalon read request.
- avm_write  out  1  Avalon write request.
- avm_writedata  out  32  write data; the byte is in [7:0], upper bits are 0.
- avm_readdata  in  32  read data.
- avm_waitrequest  in  1  slave stall.
- o_core_start  out  1  one-cycle start pulse to the core.
- o_core_n, o_core_d, o_core_a  out  256  N, d and ciphertext; held stable from the start pulse until the core reports finished.
- i_core_a_pow_d  in  256  plaintext from the core; valid only while i_core_finished is high.
- i_core_finished  in  1  one-cycle done pulse from the core.

## Operation
- States: S_POLL_RX, S_READ, S_START, S_WAIT, S_POLL_TX, S_WRITE.
- Phase register: P_N, then P_D, then P_A. P_A repeats indefinitely.
- S_POLL_RX: read STATUS_OFFSET.
  - On completion with the RX_OK_BIT bit set, go to S_READ.
  - Otherwise stay in S_POLL_RX and issue the next status read.
- S_READ: read RX_OFFSET. On completion, shift the byte in MSB-first: reg <= {reg[247:0], readdata[7:0]}. Then increment the byte counter.
- Byte counter: 6 bits, range 0..31.
  - When byte 31 completes, the counter wraps to 0.
  - Phase advances P_N→P_D→P_A. From P_A the next state is S_START; from the other phases it returns to S_POLL_RX.
- S_START: assert o_core_start for exactly one cycle, then go to S_WAIT.
- S_WAIT: when i_core_finished is high, capture i_core_a_pow_d into the output shift register in the same cycle. Then go to S_POLL_TX.
- S_POLL_TX: read status; go to S_WRITE when the TX_OK_BIT bit is set.
- S_WRITE: write the output byte [247:240] to TX_OFFSET (31-byte mode).
  - On completion, shift the output register left by 8.
  - After the last byte, return to S_POLL_RX with phase P_A. N and d are retained.
- Avalon rules:
  - A transaction completes on a cycle where read or write is high and avm_waitrequest is low.
  - Address, read, write and writedata stay constant while waitrequest is high.
  - Read and write are never asserted together.
- A high avm_readdata value is sampled only on a completion cycle.
- i_core_finished arriving outside S_WAIT is ignored.

## Timing
- Reset values: all outputs 0, state S_POLL_RX, phase P_N, counters 0. Reset mid-transfer aborts immediately; N and d must be reloaded.
- With waitrequest held low and the status bit always ready, each byte costs 2 cycles (status, then data).
  - Each key or ciphertext load: 64 cycles.
  - Plaintext drain: 62 cycles (31 bytes).
- o_core_start is asserted in the cycle after the 32nd ciphertext byte completes.
- The first TX status read is issued in the cycle after i_core_finished is sampled.
- Status-not-ready retries are issued back to back with no idle cycle.

## Configuration
- RSA_FULL_OUT_EN defined:
  - All 32 plaintext bytes are transmitted, starting with [255:248].
  - Drain takes 64 cycles minimum.
- RSA_FULL_OUT_EN undefined:
  - Only 31 bytes are transmitted, [247:0]; the top byte is dropped, since plaintext < N.
  - Drain takes 62 cycles minimum.

## Structure
- Shared package rsa_pkg holds:
  - the state enum and the phase enum;
  - the default register offsets and the RX/TX status bit positions;
  - KEY_BYTES=32;
  - OUT_BYTES, whose value depends on the macro.
- Natural sub-module: rsa_uart_byte_port. It performs one status poll plus one data read or write handshake. Its byte interface is req/we/byte_in/done/byte_out.

## Test plan
- Feed bytes 0x01..0x20 for N, then 0x21..0x40 for d.
  - Required: o_core_n = 0x0102…1F20 and o_core_d = 0x2122…3F40 at the start pulse.
  - Exactly 128 Avalon transactions occur, with waitrequest held low.
- Feed ciphertext bytes 0xA0..0xBF; the core model returns 0x00112233…EEFF (32 bytes) after 10 cycles.
  - Required: one o_core_start pulse.
  - TX writedata sequence is 0x11,0x22,…,0xFF (31 writes; 32 writes starting with 0x00 with RSA_FULL_OUT_EN).
- Hold RX_OK low for 5 status reads before each byte.
  - Required: 5 extra status reads per byte, no data read until the bit is set, and assembled values unchanged.
- Assert avm_waitrequest randomly (about 50%).
  - Required: address, read, write and writedata stay stable under stall, and results match the no-stall run.
- Run two ciphertext blocks back to back.
  - Required: N and d are not re-read.
  - The second block's plaintext is transmitted, and o_core_start fires once per block.
- Drop i_rst after byte 15 of d.
  - Required: outputs are 0 at once, and the next 32 bytes are loaded as N.

Source files
------------

// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA UART/Avalon bridge.
// OUT_BYTES follows RSA_FULL_OUT_EN: 32 when defined, else 31.
package rsa_pkg;

    typedef enum logic [2:0] {
        S_POLL_RX,
        S_READ,
        S_START,
        S_WAIT,
        S_POLL_TX,
        S_WRITE
    } state_t;

    typedef enum logic [1:0] {
        P_N,
        P_D,
        P_A
    } phase_t;

    typedef enum logic {
        B_STAT,
        B_DATA
    } port_t;

    localparam logic [4:0] RX_OFFSET     = 5'd0;
    localparam logic [4:0] TX_OFFSET     = 5'd4;
    localparam logic [4:0] STATUS_OFFSET = 5'd8;

    localparam int RX_OK_BIT = 7;
    localparam int TX_OK_BIT = 6;
    localparam int KEY_BYTES = 32;

`ifdef RSA_FULL_OUT_EN
    localparam int OUT_BYTES = 32;
`else
    localparam int OUT_BYTES = 31;
`endif

    localparam logic [5:0] LAST_KEY = 6'(KEY_BYTES - 1);
    localparam logic [5:0] LAST_OUT = 6'(OUT_BYTES - 1);

endpackage

// File: rtl/rsa_avalon_bridge_if.sv
// Avalon-MM bus between the bridge (master) and the UART (slave).
// address/read/write/writedata go out, readdata/waitrequest come in.
interface rsa_avalon_bridge_if;

    logic [4:0]  avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata;
    logic        avm_waitrequest;

    modport master (
        output avm_address,
        output avm_read,
        output avm_write,
        output avm_writedata,
        input  avm_readdata,
        input  avm_waitrequest
    );

    modport slave (
        input  avm_address,
        input  avm_read,
        input  avm_write,
        input  avm_writedata,
        output avm_readdata,
        output avm_waitrequest
    );

endinterface

// File: rtl/rsa_uart_byte_port.sv
// One UART byte transfer: status poll until ready, then data read/write.
// Ports: i_req/i_we/i_byte_in in; o_stat_ok, o_done, o_byte_out out; avm bus.
module rsa_uart_byte_port
    import rsa_pkg::*;
(
    input  logic                       i_clk,
    input  logic                       i_rst,
    rsa_avalon_bridge_if.master        avm,
    input  logic                       i_req,
    input  logic                       i_we,
    input  logic [7:0]                 i_byte_in,
    output logic                       o_stat_ok,
    output logic                       o_done,
    output logic [7:0]                 o_byte_out
);

    port_t r_st;
    port_t w_st_nxt;
    logic  w_ack;
    logic  w_ok_bit;

    assign w_ack      = ~avm.avm_waitrequest;
    assign w_ok_bit   = i_we ? avm.avm_readdata[TX_OK_BIT]
                             : avm.avm_readdata[RX_OK_BIT];
    assign o_byte_out = avm.avm_readdata[7:0];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_st <= B_STAT;
        else        r_st <= w_st_nxt;
    end

    // Request lines depend only on state and i_req, so they hold
    // steady while the slave stalls.
    always_comb begin
        w_st_nxt          = r_st;
        avm.avm_address   = '0;
        avm.avm_read      = 1'b0;
        avm.avm_write     = 1'b0;
        avm.avm_writedata = '0;
        o_stat_ok         = 1'b0;
        o_done            = 1'b0;
        if (i_req) begin
            case (r_st)
                B_STAT: begin
                    avm.avm_read    = 1'b1;
                    avm.avm_address = STATUS_OFFSET;
                    if (w_ack && w_ok_bit) begin
                        o_stat_ok = 1'b1;
                        w_st_nxt  = B_DATA;
                    end
                end
                default: begin
                    if (i_we) begin
                        avm.avm_write     = 1'b1;
                        avm.avm_address   = TX_OFFSET;
                        avm.avm_writedata = {24'd0, i_byte_in};
                    end else begin
                        avm.avm_read    = 1'b1;
                        avm.avm_address = RX_OFFSET;
                    end
                    if (w_ack) begin
                        o_done   = 1'b1;
                        w_st_nxt = B_STAT;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/rsa_avalon_bridge.sv
// Feeds N, d and ciphertext blocks from the UART to the RSA core and
// streams plaintext back. Ports: i_clk, i_rst, avm bus, core start/N/d/a,
// core result/finished. RSA_FULL_OUT_EN sends all 32 result bytes.
module rsa_avalon_bridge
    import rsa_pkg::*;
(
    input  logic                i_clk,
    input  logic                i_rst,
    rsa_avalon_bridge_if.master avm,
    output logic                o_core_start,
    output logic [255:0]        o_core_n,
    output logic [255:0]        o_core_d,
    output logic [255:0]        o_core_a,
    input  logic [255:0]        i_core_a_pow_d,
    input  logic                i_core_finished
);

    state_t       r_state;
    state_t       w_next;
    phase_t       r_phase;
    logic [5:0]   r_cnt;
    logic         r_run;
    logic [255:0] r_n;
    logic [255:0] r_d;
    logic [255:0] r_a;
    logic [255:0] r_out;
    logic         w_req;
    logic         w_we;
    logic         w_stat_ok;
    logic         w_done;
    logic [7:0]   w_rx_byte;
    logic [7:0]   w_tx_byte;

    assign w_we      = (r_state == S_POLL_TX) || (r_state == S_WRITE);
    // r_run keeps the bus idle while reset is held.
    assign w_req     = r_run && (w_we || (r_state == S_POLL_RX)
                                      || (r_state == S_READ));
    assign w_tx_byte = r_out[OUT_BYTES*8-1 -: 8];

    assign o_core_start = (r_state == S_START);
    assign o_core_n     = r_n;
    assign o_core_d     = r_d;
    assign o_core_a     = r_a;

    rsa_uart_byte_port u_port (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .avm        (avm),
        .i_req      (w_req),
        .i_we       (w_we),
        .i_byte_in  (w_tx_byte),
        .o_stat_ok  (w_stat_ok),
        .o_done     (w_done),
        .o_byte_out (w_rx_byte)
    );

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state <= S_POLL_RX;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_POLL_RX: if (w_stat_ok) w_next = S_WRITE == S_WRITE ? S_READ : S_READ;
            S_READ: begin
                if (w_done) begin
                    if (r_cnt == LAST_KEY && r_phase == P_A) w_next = S_START;
                    else                                    w_next = S_POLL_RX;
                end
            end
            S_START:   w_next = S_WAIT;
            S_WAIT:    if (i_core_finished) w_next = S_POLL_TX;
            S_POLL_TX: if (w_stat_ok) w_next = S_WRITE;
            S_WRITE: begin
                if (w_done) begin
                    if (r_cnt == LAST_OUT) w_next = S_POLL_RX;
                    else                   w_next = S_POLL_TX;
                end
            end
            default:   w_next = S_POLL_RX;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_phase <= P_N;
            r_cnt   <= '0;
            r_n     <= '0;
            r_d     <= '0;
            r_a     <= '0;
            r_out   <= '0;
        end else begin
            if (r_state == S_READ && w_done) begin
                case (r_phase)
                    P_N:     r_n <= {r_n[247:0], w_rx_byte};
                    P_D:     r_d <= {r_d[247:0], w_rx_byte};
                    default: r_a <= {r_a[247:0], w_rx_byte};
                endcase
                if (r_cnt == LAST_KEY) begin
                    r_cnt <= '0;
                    if (r_phase == P_N) r_phase <= P_D;
                    else                r_phase <= P_A;
                end else begin
                    r_cnt <= r_cnt + 6'd1;
                end
            end
            if (r_state == S_WAIT && i_core_finished) r_out <= i_core_a_pow_d;
            if (r_state == S_WRITE && w_done) begin
                r_out <= r_out << 8;
                if (r_cnt == LAST_OUT) r_cnt <= '0;
                else                   r_cnt <= r_cnt + 6'd1;
            end
        end
    end

endmodule

// File: tb/tb_rsa_avalon_bridge.sv
// Self-checking bench for rsa_avalon_bridge: UART slave and core models,
// table of scenarios, mid-load reset sequence.
module tb_rsa_avalon_bridge;

`ifdef RSA_FULL_OUT_EN
    localparam int NOUT = 32;
`else
    localparam int NOUT = 31;
`endif

    logic         i_clk = 1'b0;
    logic         i_rst = 1'b0;
    logic         o_core_start;
    logic [255:0] o_core_n;
    logic [255:0] o_core_d;
    logic [255:0] o_core_a;
    logic [255:0] i_core_a_pow_d;
    logic         i_core_finished;

    always #5 i_clk = ~i_clk;

    rsa_avalon_bridge_if bus ();

    rsa_avalon_bridge dut (
        .i_clk           (i_clk),
        .i_rst           (i_rst),
        .avm             (bus),
        .o_core_start    (o_core_start),
        .o_core_n        (o_core_n),
        .o_core_d        (o_core_d),
        .o_core_a        (o_core_a),
        .i_core_a_pow_d  (i_core_a_pow_d),
        .i_core_finished (i_core_finished)
    );

    typedef struct {
        int nrdy;
        int wpct;
        int nblk;
        bit fixed;
        bit spur;
        int exp_starts;
        int exp_rx;
        int exp_tx;
    } row_t;

    row_t rows[6];

    int nc = 0;
    int nf = 0;
    int cyc = 0;
    logic [7:0]   rxq[$];
    logic [7:0]   exptx[$];
    logic [255:0] expa[$];
    logic [255:0] exp_n, exp_d, core_val, a_held, fixed_pt;
    int nrdy, wpct, stat_since, ntrans, rx_reads, tx_cnt, nstarts;
    int core_cnt, fin_cyc, last_a_cyc, rx32_cyc;
    bit spur, fixed_next, stalled, req, stall, legal;
    logic [4:0]  s_addr;
    logic        s_rd, s_wr;
    logic [31:0] s_wd, rd;

    task automatic chk(input string nm, input logic [255:0] act,
                       input logic [255:0] exp);
        nc++;
        if (act !== exp) begin
            nf++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] v = '0;
        for (int i = 0; i < 8; i++) v = {v[223:0], $urandom};
        return v;
    endfunction

    function automatic row_t mk(int r, int w, int b, bit f, bit s);
        row_t x;
        x.nrdy = r; x.wpct = w; x.nblk = b; x.fixed = f; x.spur = s;
        x.exp_starts = b;
        x.exp_rx = 64 + 32 * b;
        x.exp_tx = NOUT * b;
        return x;
    endfunction

    // One clock cycle of the UART slave and core models, evaluated at the
    // negedge; completions take effect at the following posedge.
    task automatic tick();
        if (stalled)
            chk("stall_hold",
                {bus.avm_address, bus.avm_read, bus.avm_write, bus.avm_writedata},
                {s_addr, s_rd, s_wr, s_wd});
        chk("rd_wr_excl", 256'(bus.avm_read & bus.avm_write), 0);

        if (core_cnt > 0) begin
            core_cnt--;
            if (core_cnt == 0) begin
                chk("core_a_held", o_core_a, a_held);
                i_core_finished = 1'b1;
                i_core_a_pow_d  = core_val;
                fin_cyc = cyc;
            end else begin
                i_core_finished = 1'b0;
                i_core_a_pow_d  = rand256();
            end
        end else begin
            i_core_finished = spur && ($urandom_range(7) == 0);
            i_core_a_pow_d  = rand256();
        end

        if (cyc == fin_cyc + 1)
            chk("tx_poll_after_fin", {bus.avm_read, bus.avm_address}, {1'b1, 5'd8});

        if (o_core_start) begin
            nstarts++;
            chk("start_latency", 256'(cyc), 256'(last_a_cyc + 1));
            chk("core_n", o_core_n, exp_n);
            chk("core_d", o_core_d, exp_d);
            if (expa.size() > 0) begin
                a_held = expa.pop_front();
                chk("core_a", o_core_a, a_held);
            end else begin
                chk("unexpected_start", 256'(expa.size()), 1);
            end
            core_cnt = 10;
            core_val = fixed_next ? fixed_pt : rand256();
            fixed_next = 1'b0;
            for (int i = 0; i < NOUT; i++)
                exptx.push_back(core_val[8*(NOUT-1-i) +: 8]);
        end

        req   = bus.avm_read | bus.avm_write;
        stall = int'($urandom_range(99)) < wpct;
        bus.avm_waitrequest = stall;
        rd = $urandom;
        if (bus.avm_read && !stall && bus.avm_address == 5'd8)
            rd[7:6] = {(rxq.size() > 0) && (stat_since >= nrdy), 1'b1};
        if (bus.avm_read && !stall && bus.avm_address == 5'd0 && rxq.size() > 0)
            rd[7:0] = rxq[0];
        bus.avm_readdata = rd;

        if (req && !stall) begin
            ntrans++;
            legal = (bus.avm_read && (bus.avm_address == 5'd8 || bus.avm_address == 5'd0))
                 || (bus.avm_write && bus.avm_address == 5'd4);
            chk("legal_access", 256'(legal), 1);
            if (bus.avm_read && bus.avm_address == 5'd8) begin
                stat_since++;
            end else if (bus.avm_read && bus.avm_address == 5'd0) begin
                chk("status_reads_per_byte", 256'(stat_since), 256'(nrdy + 1));
                chk("rx_nonempty", 256'(rxq.size() > 0), 1);
                if (rxq.size() > 0) void'(rxq.pop_front());
                rx_reads++;
                stat_since = 0;
                if (rx_reads == 32) rx32_cyc = cyc;
                if (rx_reads == 64) begin
                    chk("load_trans", 256'(ntrans), 256'(64 * (nrdy + 2)));
                    if (wpct == 0)
                        chk("d_load_cycles", 256'(cyc - rx32_cyc), 256'(32 * (nrdy + 2)));
                end
                if (rx_reads >= 96 && rx_reads % 32 == 0) last_a_cyc = cyc;
            end else if (bus.avm_write) begin
                if (exptx.size() > 0)
                    chk("tx_byte", bus.avm_writedata, {24'd0, exptx.pop_front()});
                else
                    chk("tx_unexpected", 256'(exptx.size()), 1);
                tx_cnt++;
                stat_since = 0;
                if (tx_cnt % NOUT == 0 && wpct == 0)
                    chk("drain_cycles", 256'(cyc - fin_cyc), 256'(2 * NOUT));
            end
        end

        stalled = req && stall;
        s_addr = bus.avm_address;
        s_rd   = bus.avm_read;
        s_wr   = bus.avm_write;
        s_wd   = bus.avm_writedata;
        cyc++;
        @(negedge i_clk);
    endtask

    task automatic do_reset();
        i_rst = 1'b0;
        #1;
        chk("rst_core_n", o_core_n, 0);
        chk("rst_core_d", o_core_d, 0);
        chk("rst_core_a", o_core_a, 0);
        chk("rst_start", 256'(o_core_start), 0);
        chk("rst_bus", {bus.avm_address, bus.avm_read, bus.avm_write, bus.avm_writedata}, 0);
        @(negedge i_clk);
        rxq.delete(); exptx.delete(); expa.delete();
        stat_since = 0; ntrans = 0; rx_reads = 0; tx_cnt = 0; nstarts = 0;
        core_cnt = 0; fin_cyc = -100; last_a_cyc = -100; rx32_cyc = 0;
        stalled = 1'b0; exp_n = '0; exp_d = '0;
        i_core_finished = 1'b0;
        bus.avm_waitrequest = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic fill(input row_t r);
        logic [7:0]   b;
        logic [255:0] a;
        nrdy = r.nrdy; wpct = r.wpct; spur = r.spur; fixed_next = r.fixed;
        for (int i = 0; i < 32; i++) begin
            b = r.fixed ? 8'(i + 1) : 8'($urandom);
            rxq.push_back(b);
            exp_n = {exp_n[247:0], b};
        end
        for (int i = 0; i < 32; i++) begin
            b = r.fixed ? 8'(i + 33) : 8'($urandom);
            rxq.push_back(b);
            exp_d = {exp_d[247:0], b};
        end
        for (int k = 0; k < r.nblk; k++) begin
            a = '0;
            for (int i = 0; i < 32; i++) begin
                b = (r.fixed && k == 0) ? 8'(8'hA0 + i) : 8'($urandom);
                rxq.push_back(b);
                a = {a[247:0], b};
            end
            expa.push_back(a);
        end
    endtask

    task automatic run_row(input row_t r);
        int budget = 0;
        do_reset();
        fill(r);
        i_rst = 1'b1;
        while ((tx_cnt < r.exp_tx || nstarts < r.exp_starts) && budget < 20000) begin
            tick();
            budget++;
        end
        chk("row_in_time", 256'(budget < 20000), 1);
        repeat (30) tick();
        chk("starts", 256'(nstarts), 256'(r.exp_starts));
        chk("rx_reads", 256'(rx_reads), 256'(r.exp_rx));
        chk("tx_writes", 256'(tx_cnt), 256'(r.exp_tx));
        chk("tx_left", 256'(exptx.size()), 0);
    endtask

    initial begin
        int budget;
        bus.avm_readdata    = '0;
        bus.avm_waitrequest = 1'b0;
        i_core_finished     = 1'b0;
        i_core_a_pow_d      = '0;
        fixed_pt = '0;
        for (int i = 0; i < 32; i++)
            fixed_pt = {fixed_pt[247:0], 8'((i % 16) * 17)};

        rows[0] = mk(0, 0, 1, 1'b1, 1'b0);
        rows[1] = mk(5, 0, 1, 1'b1, 1'b0);
        rows[2] = mk(0, 50, 1, 1'b1, 1'b0);
        rows[3] = mk(0, 0, 2, 1'b0, 1'b1);
        rows[4] = mk(2, 40, 2, 1'b0, 1'b1);
        rows[5] = mk(1, 0, 1, 1'b0, 1'b0);

        @(negedge i_clk);
        for (int i = 0; i < 5; i++) run_row(rows[i]);

        // Reset while d is half loaded; the next load must start at N.
        do_reset();
        fill(mk(0, 0, 1, 1'b0, 1'b0));
        i_rst = 1'b1;
        budget = 0;
        while (rx_reads < 48 && budget < 2000) begin
            tick();
            budget++;
        end
        chk("abort_point", 256'(rx_reads), 48);
        chk("pre_abort_n", o_core_n, exp_n);
        run_row(rows[5]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nf);
        $finish;
    end

endmodule
